// File: rtl/prog_loader.sv
// Framed program loader: writes header-described payload into shared RAM, then raises start.
// Define LOADER_CHECKSUM_EN to require a trailing mod-2^32 sum word after the payload.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [15:0] MAGIC  = 16'hB007
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              start,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
`ifdef LOADER_CHECKSUM_EN
    StChk,
`endif
    StSettle,
    StRun,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              wr_en_d;
  logic              beat;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  assign beat = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (load_req) begin
      // Restart wins over any beat in the same cycle; that beat is dropped.
      state_d = StHdr;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      case (state_q)
        StIdle: ;
        StHdr: begin
          if (beat) begin
            if (in_data[31:16] != MAGIC) begin
              state_d = StErr;
            end else begin
              addr_d  = ADDR_W'(in_data[7:0]);
              cnt_d   = {1'b0, in_data[15:8]} + 9'd1;
              state_d = StLoad;
`ifdef LOADER_CHECKSUM_EN
              sum_d   = '0;
`endif
            end
          end
        end
        StLoad: begin
          if (beat) begin
            wr_en_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + in_data;
            if (cnt_q == 9'd1) state_d = StChk;
`else
            if (cnt_q == 9'd1) state_d = StSettle;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (beat) state_d = (in_data == sum_q) ? StSettle : StErr;
        end
`endif
        // One spare cycle so the final RAM write lands before the cores start.
        StSettle: state_d = StRun;
        StRun:    ;
        StErr:    ;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
      in_ready <= (state_d == StHdr) || (state_d == StLoad) || (state_d == StChk);
      busy     <= (state_d == StHdr) || (state_d == StLoad) || (state_d == StChk) ||
                  (state_d == StSettle);
`else
      in_ready <= (state_d == StHdr) || (state_d == StLoad);
      busy     <= (state_d == StHdr) || (state_d == StLoad) || (state_d == StSettle);
`endif
      start    <= (state_d == StRun);
      err      <= (state_d == StErr);
      wr_en    <= wr_en_d;
      if (wr_en_d) begin
        wr_addr <= addr_q;
        wr_data <= in_data;
      end
    end
  end

endmodule
